multicycle_pc_sequencer: RTL
============================

// Module: multicycle_pc_sequencer
// PURPOSE
//  Parametrised stage sequencer and program counter for the multicycle RISC-V core.
//  - Replaces the free-running 5-count cycle counter with an explicit FSM that waits on fetch and memory handshakes.
//  - Holds the PC and the signed/unsigned branch comparator (RV32I funct3 decode).
//  - Emits one-cycle stage strobes that gate ROM, RAM and register-file writes.
// PARAMETERS
//  XLEN      32  datapath/PC width
//  RESET_PC  0   PC value loaded on reset
//  PC_STEP   4   PC increment for sequential flow
// PORTS
//  clk          in   1     clock, all state on rising edge
//  rst          in   1     synchronous reset, active-low
//  fetch_ack    in   1     instruction word valid from ROM
//  mem_ack      in   1     RAM access complete
//  is_branch    in   1     decoded conditional branch
//  is_jump      in   1     decoded JAL/JALR
//  is_mem       in   1     decoded load/store
//  halt         in   1     stop after current instruction's WB
//  funct3       in   3     branch condition
//  rs1_val      in   XLEN  comparator operand A
//  rs2_val      in   XLEN  comparator operand B
//  target       in   XLEN  ALU-computed branch/jump target
//  pc           out  XLEN  current instruction address
//  stage        out  3     0 FETCH, 1 DECODE, 2 EXEC, 3 MEM, 4 WB, 5 HALT
//  fetch_req    out  1     high throughout FETCH
//  mem_req      out  1     high throughout MEM when is_mem
//  wb_en        out  1     one-cycle register-file write strobe
//  br_eq, br_lt out  1     registered comparator flags (valid from MEM onward)
//  br_taken     out  1     registered redirect decision
// BEHAVIOUR
//  - Reset (rst==0 at edge): stage=FETCH, pc=RESET_PC, all strobes/flags 0. Reset overrides every state, mid-handshake included.
//  - Requests are dropped at reset; a late ack is ignored.
//  - FETCH: fetch_req=1. Leave on the edge where fetch_ack=1, else hold.
//  - DECODE: exactly 1 cycle.
//  - EXEC: 1 cycle. Latch br_eq=(rs1==rs2).
//    - br_lt uses signed compare for funct3 100/101 and unsigned for 110/111.
//  - br_taken rule, latched in EXEC:
//    - is_jump=1: always taken.
//    - else is_branch=1, by funct3:
//      - 000: eq
//      - 001: !eq
//      - 100/110: lt
//      - 101/111: !lt
//      - 010/011: 0
//    - else: 0.
//  - MEM: when is_mem, mem_req=1 until the edge where mem_ack=1. When !is_mem, exactly 1 cycle, mem_req=0.
//  - WB: wb_en=1 for exactly this cycle. At its exit edge, pc update:
//    - br_taken: pc <= {target[XLEN-1:1],1'b0}
//    - else: pc <= pc+PC_STEP, modulo 2^XLEN, so all-ones wraps.
//  - Next state after WB: HALT if halt=1 in WB, else FETCH.
//  - HALT: all strobes 0, pc frozen; exit only via reset.
//  - Minimum latency: 5 cycles per instruction with single-cycle acks.
//  - Each wait adds 1 cycle per deasserted-ack cycle.
//  - Ack asserted outside its stage is ignored.
//  - Decode inputs are sampled only in EXEC/WB. They must be held stable from DECODE through WB.
// CONFIGURATION
//  - PERF_COUNTERS_EN defined:
//    - Adds outputs cycle_cnt[63:0] and instret_cnt[63:0], both 0 on reset.
//    - cycle_cnt increments every non-HALT cycle.
//    - instret_cnt increments on each WB exit.
//    - Both wrap silently.
//  - Undefined: ports absent, no counter logic.
// TESTING
//  1. rst=0 two cycles, then acks tied 1 -> pc=0, stage sequence 0,1,2,3,4,0; pc=4 after first WB.
//  2. fetch_ack low 3 cycles in FETCH -> fetch_req held 4 cycles; instruction takes 8 cycles total.
//  3. is_branch, funct3=100, rs1=32'hFFFFFFFF, rs2=1, target=0x40 -> br_lt=1, br_taken=1, next pc=0x40.
//  4. Same operands with funct3=110 -> br_lt=0, br_taken=0, next pc=pc+4.
//  5. is_jump, target=0x101 -> next pc=0x100. Then pc=0xFFFFFFFC sequential -> wraps to 0.
//  6. is_mem with mem_ack delayed 2 cycles, then rst=0 during the MEM wait -> mem_req drops, stage=FETCH, pc=RESET_PC.
//     - Also: halt in WB -> stage=5 held 10 cycles, pc frozen.
//     - With PERF_COUNTERS_EN: instret_cnt stops while cycle_cnt freezes.

Source files
------------

// File: rtl/multicycle_pc_sequencer.sv
// Stage sequencer, program counter and branch comparator for the multicycle RISC-V core.
// Optional `PERF_COUNTERS_EN adds cycle_cnt/instret_cnt outputs.
module multicycle_pc_sequencer #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              PC_STEP  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fetch_ack,
  input  logic            mem_ack,
  input  logic            is_branch,
  input  logic            is_jump,
  input  logic            is_mem,
  input  logic            halt,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [XLEN-1:0] target,
  output logic [XLEN-1:0] pc,
  output logic [2:0]      stage,
  output logic            fetch_req,
  output logic            mem_req,
  output logic            wb_en,
  output logic            br_eq,
  output logic            br_lt,
  output logic            br_taken
`ifdef PERF_COUNTERS_EN
  ,
  output logic [63:0]     cycle_cnt,
  output logic [63:0]     instret_cnt
`endif
);

  localparam logic [2:0] FETCH  = 3'd0;
  localparam logic [2:0] DECODE = 3'd1;
  localparam logic [2:0] EXEC   = 3'd2;
  localparam logic [2:0] MEM    = 3'd3;
  localparam logic [2:0] WB     = 3'd4;
  localparam logic [2:0] HALT   = 3'd5;

  localparam logic [XLEN-1:0] STEP     = XLEN'(PC_STEP);
  localparam logic [XLEN-1:0] LSB_MASK = ~XLEN'(1);

  logic [2:0]      state_reg, state_next;
  logic [XLEN-1:0] pc_reg, pc_next;
  logic            mem_op_reg;
  logic            br_eq_reg, br_lt_reg, br_taken_reg;

  logic cmp_eq, cmp_lt_s, cmp_lt_u, cmp_lt, taken_next;

  assign cmp_eq   = (rs1_val == rs2_val);
  assign cmp_lt_s = ($signed(rs1_val) < $signed(rs2_val));
  assign cmp_lt_u = (rs1_val < rs2_val);
  // funct3[1] distinguishes BLTU/BGEU from BLT/BGE
  assign cmp_lt   = funct3[1] ? cmp_lt_u : cmp_lt_s;

  always_comb begin
    taken_next = 1'b0;
    if (is_jump) begin
      taken_next = 1'b1;
    end else if (is_branch) begin
      case (funct3)
        3'b000:          taken_next = cmp_eq;
        3'b001:          taken_next = !cmp_eq;
        3'b100, 3'b110:  taken_next = cmp_lt;
        3'b101, 3'b111:  taken_next = !cmp_lt;
        default:         taken_next = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      FETCH:   if (fetch_ack) state_next = DECODE;
      DECODE:  state_next = EXEC;
      EXEC:    state_next = MEM;
      MEM:     if (!mem_op_reg || mem_ack) state_next = WB;
      WB:      state_next = halt ? HALT : FETCH;
      HALT:    state_next = HALT;
      default: state_next = FETCH;
    endcase
  end

  always_comb begin
    pc_next = pc_reg;
    if (state_reg == WB) begin
      pc_next = br_taken_reg ? (target & LSB_MASK) : (pc_reg + STEP);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg    <= FETCH;
      pc_reg       <= RESET_PC;
      mem_op_reg   <= 1'b0;
      br_eq_reg    <= 1'b0;
      br_lt_reg    <= 1'b0;
      br_taken_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      // Decode inputs are captured once so MEM/WB do not depend on them later
      if (state_reg == EXEC) begin
        mem_op_reg   <= is_mem;
        br_eq_reg    <= cmp_eq;
        br_lt_reg    <= cmp_lt;
        br_taken_reg <= taken_next;
      end
    end
  end

  assign pc        = pc_reg;
  assign stage     = state_reg;
  assign fetch_req = (state_reg == FETCH);
  assign mem_req   = (state_reg == MEM) && mem_op_reg;
  assign wb_en     = (state_reg == WB);
  assign br_eq     = br_eq_reg;
  assign br_lt     = br_lt_reg;
  assign br_taken  = br_taken_reg;

`ifdef PERF_COUNTERS_EN
  logic [63:0] cycle_cnt_reg, instret_cnt_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cycle_cnt_reg   <= '0;
      instret_cnt_reg <= '0;
    end else begin
      if (state_reg != HALT) cycle_cnt_reg <= cycle_cnt_reg + 64'd1;
      if (state_reg == WB)   instret_cnt_reg <= instret_cnt_reg + 64'd1;
    end
  end

  assign cycle_cnt   = cycle_cnt_reg;
  assign instret_cnt = instret_cnt_reg;
`endif

endmodule
